// File: rtl/mips_boot_pkg.sv
// Shared types and widths for the IITK_MIPS boot loader.
package mips_boot_pkg;

  localparam int unsigned LEN_W  = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    PAYLOAD,
    CSUM,
    HOLD,
    RUN,
    ERR
  } boot_state_e;

  // Image length must be non-zero and fit the instruction memory budget.
  function automatic logic len_ok(input logic [LEN_W-1:0] n, input int unsigned max_words);
    return (n != '0) && (32'(n) <= max_words);
  endfunction

endpackage

// File: rtl/boot_word_packer.sv
// Packs little-endian bytes into 32-bit words; flags the word on its 4th byte.
module boot_word_packer
  import mips_boot_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              byte_valid_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic              word_valid_c,
  output logic [WORD_W-1:0] word_c
);

  localparam int unsigned HOLD_W = WORD_W - BYTE_W;

  logic [1:0]        idx_q, idx_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q  <= '0;
      hold_q <= '0;
    end else begin
      idx_q  <= idx_d;
      hold_q <= hold_d;
    end
  end

  // Oldest byte ends up in the low lane of hold_q after three shifts.
  always_comb begin
    idx_d        = idx_q;
    hold_d       = hold_q;
    word_valid_c = byte_valid_i && (idx_q == 2'd3);
    word_c       = {byte_i, hold_q};
    if (clear_i) begin
      idx_d  = '0;
      hold_d = '0;
    end else if (byte_valid_i) begin
      idx_d  = idx_q + 2'd1;
      hold_d = {byte_i, hold_q[HOLD_W-1:BYTE_W]};
    end
  end

endmodule

// File: rtl/mips_boot_loader.sv
// Streams a length-prefixed, XOR-checked program image into instruction memory
// and holds the MIPS core in reset until the image is verified.
module mips_boot_loader
  import mips_boot_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned MAX_WORDS  = 256,
  parameter int unsigned RESET_HOLD = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              core_reset,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned HCNT_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

  boot_state_e       state_q, state_d;
  logic [BYTE_W-1:0] len_lo_q, len_lo_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [BYTE_W-1:0] xor_q, xor_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  wc_q, wc_d;
  logic              rdy_q, core_rst_q, done_q, err_q;

  logic              accept;
  logic              pack_valid;
  logic [LEN_W-1:0]  hdr_len;
  logic              word_valid;
  logic [WORD_W-1:0] word;

  assign accept     = rx_valid && rdy_q;
  assign pack_valid = accept && (state_q == PAYLOAD);
  assign hdr_len    = {rx_data, len_lo_q};

  boot_word_packer u_packer (
    .clock        (clock),
    .reset        (reset),
    .clear_i      (state_q != PAYLOAD),
    .byte_valid_i (pack_valid),
    .byte_i       (rx_data),
    .word_valid_c (word_valid),
    .word_c       (word)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= HDR0;
      len_lo_q   <= '0;
      len_q      <= '0;
      xor_q      <= '0;
      hcnt_q     <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wc_q       <= '0;
      rdy_q      <= 1'b1;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      len_q      <= len_d;
      xor_q      <= xor_d;
      hcnt_q     <= hcnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wc_q       <= wc_d;
      rdy_q      <= state_d inside {HDR0, HDR1, PAYLOAD, CSUM};
      core_rst_q <= (state_d != RUN);
      done_q     <= (state_d == RUN);
      err_q      <= (state_d == ERR);
    end
  end

  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    len_d    = len_q;
    xor_d    = xor_q;
    hcnt_d   = '0;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wc_d     = wc_q;
    case (state_q)
      HDR0: begin
        if (accept) begin
          len_lo_d = rx_data;
          state_d  = HDR1;
        end
      end
      HDR1: begin
        if (accept) begin
          len_d   = hdr_len;
          state_d = len_ok(hdr_len, MAX_WORDS) ? PAYLOAD : ERR;
        end
      end
      PAYLOAD: begin
        if (accept) begin
          xor_d = xor_q ^ rx_data;
          if (word_valid) begin
            we_d    = 1'b1;
            addr_d  = wc_q[ADDR_W-1:0];
            wdata_d = word;
            wc_d    = wc_q + CNT_W'(1);
            if ((LEN_W'(wc_q) + LEN_W'(1)) == len_q) state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (accept) state_d = (rx_data == xor_q) ? HOLD : ERR;
      end
      HOLD: begin
        if (hcnt_q == HCNT_W'(RESET_HOLD - 1)) state_d = RUN;
        else hcnt_d = hcnt_q + HCNT_W'(1);
      end
      default: ;
    endcase
  end

  assign rx_ready   = rdy_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_reset = core_rst_q;
  assign load_done  = done_q;
  assign load_err   = err_q;
  assign word_count = wc_q;

endmodule

// File: tb/tb_mips_boot_loader.sv
// Randomised bench for mips_boot_loader with a frame-position reference model.
module tb_mips_boot_loader;

  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned MAX_WORDS  = 256;
  localparam int unsigned RESET_HOLD = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_ready, imem_we, core_reset, load_done, load_err;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   word_count;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  always #5 clock = ~clock;

  mips_boot_loader #(
    .ADDR_W     (ADDR_W),
    .MAX_WORDS  (MAX_WORDS),
    .RESET_HOLD (RESET_HOLD)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .load_done  (load_done),
    .load_err   (load_err),
    .word_count (word_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks position within the frame and the load phase.
  typedef enum logic [1:0] {LOADING, HOLDING, RUNNING, FAILED} phase_e;
  phase_e            m_phase;
  int                m_pos, m_hold, m_wc;
  logic [15:0]       m_n;
  logic [7:0]        m_xor;
  logic [31:0]       m_word;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata;

  always @(posedge clock) begin : model
    bit acc;
    int bi;
    if (reset) begin
      m_phase = LOADING; m_pos = 0; m_hold = 0; m_wc = 0;
      m_n = 16'h0; m_xor = 8'h0; m_word = 32'h0;
      m_we = 1'b0; m_addr = '0; m_wdata = 32'h0;
    end else begin
      acc  = rx_valid && (m_phase == LOADING);
      m_we = 1'b0;
      if (m_phase == HOLDING) begin
        m_hold++;
        if (m_hold == int'(RESET_HOLD)) m_phase = RUNNING;
      end else if (acc) begin
        if (m_pos == 0) m_n[7:0] = rx_data;
        else if (m_pos == 1) begin
          m_n[15:8] = rx_data;
          if (int'(m_n) < 1 || int'(m_n) > int'(MAX_WORDS)) m_phase = FAILED;
        end else if (m_pos < 2 + 4 * int'(m_n)) begin
          bi = m_pos - 2;
          m_word[8*(bi%4) +: 8] = rx_data;
          m_xor = m_xor ^ rx_data;
          if (bi % 4 == 3) begin
            m_we = 1'b1; m_addr = ADDR_W'(bi / 4); m_wdata = m_word; m_wc++;
          end
        end else begin
          if (rx_data == m_xor) begin m_phase = HOLDING; m_hold = 0; end
          else m_phase = FAILED;
        end
        m_pos++;
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clock) begin
    if (cmp_en) begin
      chk("rx_ready",   32'(rx_ready),   32'(m_phase == LOADING));
      chk("core_reset", 32'(core_reset), 32'(m_phase != RUNNING));
      chk("load_done",  32'(load_done),  32'(m_phase == RUNNING));
      chk("load_err",   32'(load_err),   32'(m_phase == FAILED));
      chk("imem_we",    32'(imem_we),    32'(m_we));
      chk("imem_addr",  32'(imem_addr),  32'(m_addr));
      chk("imem_wdata", imem_wdata,      m_wdata);
      chk("word_count", 32'(word_count), 32'(m_wc));
    end
  end

  // Record of writes actually issued to instruction memory.
  logic [31:0]       wr_mem [MAX_WORDS];
  int                wr_cnt = 0;
  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [31:0]       wr_data_q[$];
  logic [ADDR_W-1:0] ref_addr[$];
  logic [31:0]       ref_data[$];

  always @(negedge clock) begin
    if (cmp_en && imem_we === 1'b1) begin
      wr_mem[imem_addr] = imem_wdata;
      wr_cnt++;
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
    end
  end

  logic [31:0] img[$];
  logic [7:0]  frame[$];

  task automatic make_frame(input logic [15:0] n, input bit bad);
    logic [7:0] x = 8'h00;
    frame.delete();
    frame.push_back(n[7:0]);
    frame.push_back(n[15:8]);
    foreach (img[i]) begin
      logic [31:0] w;
      w = img[i];
      for (int b = 0; b < 4; b++) begin
        frame.push_back(w[8*b +: 8]);
        x = x ^ w[8*b +: 8];
      end
    end
    frame.push_back(bad ? (x ^ 8'h01) : x);
  endtask

  // Present one byte, inserting idle cycles with probability gap_pct.
  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    int tries = 0;
    bit done  = 1'b0;
    while (!done) begin
      @(negedge clock);
      if (int'($urandom_range(99)) < gap_pct) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
      end else begin
        rx_valid = 1'b1;
        rx_data  = b;
        done     = (rx_ready === 1'b1);
      end
      tries++;
      if (!done && tries > 200) begin
        checks++; failures++;
        $display("FAIL send_timeout: byte %0h not accepted, rx_ready=%0b", b, rx_ready);
        done = 1'b1;
      end
    end
  endtask

  task automatic send_frame(input int gap_pct, input int count);
    for (int i = 0; i < count; i++) send_byte(frame[i], gap_pct);
  endtask

  task automatic wait_end();
    int n = 0;
    do begin
      @(negedge clock);
      rx_valid = 1'b0;
      n++;
    end while (!(load_done === 1'b1 || load_err === 1'b1) && n < 50);
    checks++;
    if (n >= 50) begin
      failures++;
      $display("FAIL end_timeout: load_done=%0b load_err=%0b", load_done, load_err);
    end
  endtask

  // Reset with a valid byte present so the reset-wins rule is exercised.
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; rx_valid = 1'b1; rx_data = 8'h5A;
    repeat (2) @(negedge clock);
    reset = 1'b0; rx_valid = 1'b0;
    wr_cnt = 0; wr_addr_q.delete(); wr_data_q.delete();
  endtask

  initial begin
    int  n;
    bit  bad;
    @(negedge clock);
    cmp_en = 1'b1;
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_rx_ready",   32'(rx_ready),   32'd1);
    chk("rst_imem_we",    32'(imem_we),    32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    reset = 1'b0;

    // Good two-word image, back to back; measure the reset hold.
    img = '{32'h12345678, 32'hDEADBEEF};
    make_frame(16'd2, 1'b0);
    send_frame(0, frame.size());
    @(posedge clock);
    n = 0;
    while (n < 20) begin
      @(negedge clock);
      rx_valid = 1'b0;
      if (core_reset === 1'b0) break;
      n++;
    end
    chk("hold_cycles",  32'(n),          32'd4);
    chk("good_mem0",    wr_mem[0],       32'h12345678);
    chk("good_mem1",    wr_mem[1],       32'hDEADBEEF);
    chk("good_writes",  32'(wr_cnt),     32'd2);
    chk("good_done",    32'(load_done),  32'd1);
    chk("good_wcount",  32'(word_count), 32'd2);
    ref_addr = wr_addr_q;
    ref_data = wr_data_q;

    // Same image with a wrong checksum byte.
    do_reset();
    frame[frame.size()-1] = 8'h01;
    send_frame(0, frame.size());
    wait_end();
    repeat (10) begin
      @(negedge clock);
      rx_valid = 1'b1; rx_data = 8'($urandom);
    end
    @(negedge clock); rx_valid = 1'b0;
    chk("bad_err",      32'(load_err),   32'd1);
    chk("bad_core_rst", 32'(core_reset), 32'd1);
    chk("bad_ready",    32'(rx_ready),   32'd0);
    chk("bad_writes",   32'(wr_cnt),     32'd2);

    // Illegal lengths: zero and one beyond the limit.
    do_reset();
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    wait_end();
    chk("n0_err",    32'(load_err), 32'd1);
    chk("n0_writes", 32'(wr_cnt),   32'd0);
    do_reset();
    send_byte(8'h01, 0); send_byte(8'h01, 0);
    wait_end();
    chk("nmax1_err",    32'(load_err), 32'd1);
    chk("nmax1_writes", 32'(wr_cnt),   32'd0);

    // Good image with random idle gaps must write the same words.
    do_reset();
    make_frame(16'd2, 1'b0);
    send_frame(50, frame.size());
    wait_end();
    chk("gap_writes", 32'(wr_cnt), 32'(ref_addr.size()));
    for (int i = 0; i < ref_addr.size() && i < wr_addr_q.size(); i++) begin
      chk("gap_addr", 32'(wr_addr_q[i]), 32'(ref_addr[i]));
      chk("gap_data", wr_data_q[i], ref_data[i]);
    end
    chk("gap_done", 32'(load_done), 32'd1);

    // Reset after five payload bytes, then reload the whole image.
    do_reset();
    send_frame(0, 7);
    do_reset();
    chk("mid_wcount",   32'(word_count), 32'd0);
    chk("mid_core_rst", 32'(core_reset), 32'd1);
    send_frame(0, frame.size());
    wait_end();
    chk("mid_done",   32'(load_done),  32'd1);
    chk("mid_wcount_end", 32'(word_count), 32'd2);

    // Largest image, word k holds k.
    do_reset();
    img.delete();
    for (int k = 0; k < int'(MAX_WORDS); k++) img.push_back(32'(k));
    make_frame(16'(MAX_WORDS), 1'b0);
    send_frame(0, frame.size());
    wait_end();
    chk("max_writes",    32'(wr_cnt),     32'(MAX_WORDS));
    if (wr_addr_q.size() > 0) begin
      chk("max_last_addr", 32'(wr_addr_q[$]), 32'(MAX_WORDS - 1));
      chk("max_last_data", wr_data_q[$],      32'(MAX_WORDS - 1));
    end
    chk("max_wcount",    32'(word_count), 32'(MAX_WORDS));
    chk("max_done",      32'(load_done),  32'd1);

    // Random short images with gaps, occasionally corrupted.
    repeat (6) begin
      do_reset();
      n   = int'($urandom_range(1, 6));
      bad = ($urandom_range(0, 3) == 0);
      img.delete();
      for (int k = 0; k < n; k++) img.push_back($urandom);
      make_frame(16'(n), bad);
      send_frame(30, frame.size());
      wait_end();
      chk("rnd_done",   32'(load_done), 32'(!bad));
      chk("rnd_writes", 32'(wr_cnt),    32'(n));
    end

    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
